arbitro_cuenta: RTL and testbench

Arbiter and sequencer for a single shared account balance register serving two ATM front-ends (port A, port B). Each front-end posts a deposit or withdrawal through a strobe. The block buffers one request per port, grants access to the balance by arbitration, and performs the update. It reports completion and insufficient funds back to the requesting port. It sits between the per-terminal ATM controllers and the account balance storage.

---
 rtl/arbitro_cuenta.sv | 158 +++++++++++++++
 tb/tb_arbitro_cuenta.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/arbitro_cuenta.sv
// arbitro_cuenta: buffers one deposit/withdrawal per ATM port and serialises them onto a shared balance.
// Define ARBITRO_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority to port A.
module arbitro_cuenta #(
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cargar_balance_i,
    input  logic [ANCHO_BALANCE-1:0] balance_inicial_i,
    input  logic                     stb_a_i,
    input  logic                     tipo_a_i,
    input  logic [ANCHO_MONTO-1:0]   monto_a_i,
    input  logic                     stb_b_i,
    input  logic                     tipo_b_i,
    input  logic [ANCHO_MONTO-1:0]   monto_b_i,
    output logic                     ocupado_a_o,
    output logic                     ocupado_b_o,
    output logic                     done_a_o,
    output logic                     done_b_o,
    output logic                     fondos_insuf_a_o,
    output logic                     fondos_insuf_b_o,
    output logic [ANCHO_BALANCE-1:0] balance_o
);
    localparam int NP = 2;  // index 0 = port A, index 1 = port B

    typedef enum logic {IDLE, EXEC} estado_t;

    logic [NP-1:0]                  stb, tipo;
    logic [NP-1:0][ANCHO_MONTO-1:0] monto;

    assign stb   = {stb_b_i, stb_a_i};
    assign tipo  = {tipo_b_i, tipo_a_i};
    assign monto = {monto_b_i, monto_a_i};

    // Per-port request buffers
    logic [NP-1:0]                  pend_q, pend_d, ocupado_q, ocupado_d, tipo_q, tipo_d;
    logic [NP-1:0][ANCHO_MONTO-1:0] monto_q, monto_d;
    logic [NP-1:0]                  concede, fin;

    // Sequencer state
    estado_t                  estado_q;
    logic                     activo_q;
    logic [ANCHO_BALANCE-1:0] balance_q;
    logic [NP-1:0]            done_q, insuf_q;
    logic                     ganador;

    always_comb begin
        pend_d    = pend_q;
        ocupado_d = ocupado_q;
        tipo_d    = tipo_q;
        monto_d   = monto_q;
        for (int p = 0; p < NP; p++) begin
            if (stb[p] && !ocupado_q[p]) begin
                pend_d[p]    = 1'b1;
                ocupado_d[p] = 1'b1;
                tipo_d[p]    = tipo[p];
                monto_d[p]   = monto[p];
            end
            if (concede[p]) pend_d[p] = 1'b0;
            if (fin[p])     ocupado_d[p] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q    <= '0;
            ocupado_q <= '0;
            tipo_q    <= '0;
            monto_q   <= '0;
        end else begin
            pend_q    <= pend_d;
            ocupado_q <= ocupado_d;
            tipo_q    <= tipo_d;
            monto_q   <= monto_d;
        end
    end

`ifdef ARBITRO_ROUND_ROBIN_EN
    // ptr_q holds the last granted port; reset value B makes A win first.
    logic ptr_q;

    always_comb begin
        if (&pend_q) ganador = ~ptr_q;
        else         ganador = ~pend_q[0];
    end
`else
    always_comb begin
        ganador = ~pend_q[0];
    end
`endif

    always_comb begin
        concede = '0;
        fin     = '0;
        if (estado_q == IDLE && !cargar_balance_i && (|pend_q)) concede[ganador] = 1'b1;
        if (estado_q == EXEC) fin[activo_q] = 1'b1;
    end

    // Datapath for the active request
    logic [ANCHO_BALANCE-1:0] monto_ext, balance_nuevo;
    logic [ANCHO_BALANCE:0]   suma;
    logic                     retiro, rechazo;

    assign monto_ext = ANCHO_BALANCE'(monto_q[activo_q]);
    assign suma      = {1'b0, balance_q} + {1'b0, monto_ext};
    assign retiro    = tipo_q[activo_q];
    assign rechazo   = retiro && (monto_ext > balance_q);

    always_comb begin
        if (retiro) balance_nuevo = rechazo ? balance_q : balance_q - monto_ext;
        else        balance_nuevo = suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            estado_q  <= IDLE;
            activo_q  <= 1'b0;
            balance_q <= '0;
            done_q    <= '0;
            insuf_q   <= '0;
`ifdef ARBITRO_ROUND_ROBIN_EN
            ptr_q     <= 1'b1;
`endif
        end else begin
            done_q  <= '0;
            insuf_q <= '0;
            case (estado_q)
                IDLE: begin
                    if (cargar_balance_i) begin
                        balance_q <= balance_inicial_i;
                    end else if (|pend_q) begin
                        activo_q <= ganador;
                        estado_q <= EXEC;
`ifdef ARBITRO_ROUND_ROBIN_EN
                        ptr_q    <= ganador;
`endif
                    end
                end
                EXEC: begin
                    balance_q         <= balance_nuevo;
                    done_q[activo_q]  <= 1'b1;
                    insuf_q[activo_q] <= rechazo;
                    estado_q          <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign ocupado_a_o      = ocupado_q[0];
    assign ocupado_b_o      = ocupado_q[1];
    assign done_a_o         = done_q[0];
    assign done_b_o         = done_q[1];
    assign fondos_insuf_a_o = insuf_q[0];
    assign fondos_insuf_b_o = insuf_q[1];
    assign balance_o        = balance_q;
endmodule

// File: tb/tb_arbitro_cuenta.sv
// Directed bench for arbitro_cuenta: load, deposit/withdraw, arbitration order, busy, saturation, reset.
module tb_arbitro_cuenta;
    logic        clk = 1'b0;
    logic        reset, cargar, stb_a, stb_b, tipo_a, tipo_b;
    logic [63:0] inicial, balance;
    logic [31:0] monto_a, monto_b;
    logic        ocup_a, ocup_b, done_a, done_b, insuf_a, insuf_b;
    int          errors = 0;
    int          checks = 0;

`ifdef ARBITRO_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    arbitro_cuenta #(.ANCHO_BALANCE(64), .ANCHO_MONTO(32)) dut (
        .clk_i(clk), .reset_i(reset), .cargar_balance_i(cargar), .balance_inicial_i(inicial),
        .stb_a_i(stb_a), .tipo_a_i(tipo_a), .monto_a_i(monto_a),
        .stb_b_i(stb_b), .tipo_b_i(tipo_b), .monto_b_i(monto_b),
        .ocupado_a_o(ocup_a), .ocupado_b_o(ocup_b), .done_a_o(done_a), .done_b_o(done_b),
        .fondos_insuf_a_o(insuf_a), .fondos_insuf_b_o(insuf_b), .balance_o(balance)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on port A or B; checks the full strobe-to-DONE timeline.
    task automatic txn(input logic port_b, input logic retiro, input logic [31:0] m,
                       input logic [63:0] bal_exp, input logic insuf_exp, input string tag);
        if (port_b) begin stb_b = 1'b1; tipo_b = retiro; monto_b = m; end
        else        begin stb_a = 1'b1; tipo_a = retiro; monto_a = m; end
        step();
        stb_a = 1'b0; stb_b = 1'b0;
        chk({tag, "_ocup_k"}, port_b ? ocup_b : ocup_a, 1);
        step();
        chk({tag, "_nodone_k1"}, port_b ? done_b : done_a, 0);
        step();
        chk({tag, "_done"}, port_b ? done_b : done_a, 1);
        chk({tag, "_insuf"}, port_b ? insuf_b : insuf_a, insuf_exp);
        chk({tag, "_bal"}, balance, bal_exp);
        chk({tag, "_ocup_free"}, port_b ? ocup_b : ocup_a, 0);
        step();
        chk({tag, "_done_off"}, port_b ? done_b : done_a, 0);
    endtask

    // Simultaneous A deposit 5 and B deposit 7; primero_b selects the expected winner.
    task automatic par(input logic primero_b, input logic [63:0] bal0, input string tag);
        stb_a = 1'b1; tipo_a = 1'b0; monto_a = 32'd5;
        stb_b = 1'b1; tipo_b = 1'b0; monto_b = 32'd7;
        step();
        stb_a = 1'b0; stb_b = 1'b0;
        chk({tag, "_ocup_ab"}, {ocup_a, ocup_b}, 2'b11);
        step();
        step();
        chk({tag, "_first"}, {done_a, done_b}, primero_b ? 2'b01 : 2'b10);
        chk({tag, "_bal1"}, balance, bal0 + (primero_b ? 64'd7 : 64'd5));
        step();
        chk({tag, "_gap"}, {done_a, done_b}, 2'b00);
        step();
        chk({tag, "_second"}, {done_a, done_b}, primero_b ? 2'b10 : 2'b01);
        chk({tag, "_bal2"}, balance, bal0 + 64'd12);
        step();
    endtask

    initial begin
        reset = 1'b1; cargar = 1'b0; inicial = '0;
        stb_a = 1'b0; stb_b = 1'b0; tipo_a = 1'b0; tipo_b = 1'b0; monto_a = '0; monto_b = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_bal", balance, 0);
        chk("rst_ocup", {ocup_a, ocup_b}, 2'b00);
        chk("rst_done", {done_a, done_b}, 2'b00);
        chk("rst_insuf", {insuf_a, insuf_b}, 2'b00);

        cargar = 1'b1; inicial = 64'd0;
        step();
        cargar = 1'b0;
        chk("load0", balance, 0);

        txn(1'b0, 1'b0, 32'd10000, 64'd10000, 1'b0, "depA");
        txn(1'b1, 1'b1, 32'd7000, 64'd3000, 1'b0, "wdB");
        txn(1'b0, 1'b1, 32'd900000, 64'd3000, 1'b1, "wdA_insuf");
        chk("insuf_clear", insuf_a, 0);
        txn(1'b0, 1'b1, 32'd3000, 64'd0, 1'b0, "wdA_exact");

        // Last grant was A, so round-robin serves B first in both pairs.
        par(RR, 64'd0, "par1");
        par(RR, 64'd12, "par2");

        // Re-strobe while busy is ignored
        stb_a = 1'b1; tipo_a = 1'b0; monto_a = 32'd1;
        step();
        monto_a = 32'd100;
        step();
        stb_a = 1'b0;
        step();
        chk("busy_done", done_a, 1);
        chk("busy_bal", balance, 64'd25);
        step();
        step();
        step();
        chk("busy_no2nd", done_a, 0);
        chk("busy_ocup", ocup_a, 0);
        chk("busy_bal2", balance, 64'd25);

        // Load during EXEC is dropped
        stb_a = 1'b1; tipo_a = 1'b0; monto_a = 32'd5;
        step();
        stb_a = 1'b0;
        step();
        cargar = 1'b1; inicial = 64'd999;
        step();
        cargar = 1'b0;
        chk("ldexec_done", done_a, 1);
        chk("ldexec_bal", balance, 64'd30);
        step();
        chk("ldexec_bal2", balance, 64'd30);

        cargar = 1'b1; inicial = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        cargar = 1'b0;
        chk("load_hi", balance, 64'hFFFF_FFFF_FFFF_FFF0);
        txn(1'b0, 1'b0, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sat");

        // Reset while in EXEC abandons the update
        stb_a = 1'b1; tipo_a = 1'b1; monto_a = 32'd5;
        step();
        stb_a = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstx_bal", balance, 0);
        chk("rstx_done", done_a, 0);
        chk("rstx_ocup", ocup_a, 0);
        step();
        chk("rstx_done2", done_a, 0);
        chk("rstx_bal2", balance, 0);

        // From reset both arbitration modes favour A
        par(1'b0, 64'd0, "par_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
